// File: rtl/drp_seq_pkg.sv
// Shared encodings and the bit-field merge used by the DRP read-modify-write sequencer.
package drp_seq_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_RMW   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RSP
  } state_e;

  // Widest data path the merge helper supports; callers cast down to their width.
  localparam int unsigned MERGE_W = 64;

  // Bits set in mask take the new value, the rest keep the old one.
  function automatic logic [MERGE_W-1:0] merge_field(
    input logic [MERGE_W-1:0] old_val,
    input logic [MERGE_W-1:0] mask,
    input logic [MERGE_W-1:0] new_val
  );
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/drp_rmw_sequencer.sv
// Command-level master for the bridge LB port: single WRITE, READ and READ-MODIFY-WRITE
// commands, one LB transaction at a time, with a per-transaction completion timeout.
module drp_rmw_sequencer
  import drp_seq_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH = 16,
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned C_TIMEOUT    = 4096
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    CMD_VALID_I,
  output logic                    CMD_READY_O,
  input  logic [1:0]              CMD_OP_I,
  input  logic [C_ADDR_WIDTH-1:0] CMD_ADDR_I,
  input  logic [C_DATA_WIDTH-1:0] CMD_DATA_I,
  input  logic [C_DATA_WIDTH-1:0] CMD_MASK_I,
  output logic                    RSP_VALID_O,
  input  logic                    RSP_READY_I,
  output logic [C_DATA_WIDTH-1:0] RSP_DATA_O,
  output logic                    RSP_ERR_O,
  output logic [C_ADDR_WIDTH-1:0] M_LB_WADDR,
  output logic [C_DATA_WIDTH-1:0] M_LB_WDATA,
  output logic                    M_LB_WREQ,
  output logic [C_ADDR_WIDTH-1:0] M_LB_RADDR,
  output logic                    M_LB_RREQ,
  input  logic [C_DATA_WIDTH-1:0] M_LB_RDATA,
  input  logic                    M_LB_RFINISH,
  input  logic                    M_LB_BUSY
);

  localparam int unsigned CNT_W = $clog2(C_TIMEOUT);

  state_e                  state_q, state_d;
  op_e                     op_q, op_d;
  logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_DATA_WIDTH-1:0] data_q, data_d;
  logic [C_DATA_WIDTH-1:0] mask_q, mask_d;
  logic [C_DATA_WIDTH-1:0] rd_q, rd_d;
  logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rreq_d, wreq_d;
  logic                    rsp_valid_d, rsp_err_d;
  logic [C_DATA_WIDTH-1:0] rsp_data_d;
  logic                    cmd_accept;
  logic                    timed_out;

  assign CMD_READY_O = (state_q == ST_IDLE) & ~M_LB_BUSY & ~RST_I;
  assign cmd_accept  = CMD_VALID_I & CMD_READY_O;
  assign timed_out   = (cnt_q == CNT_W'(C_TIMEOUT - 1));

  // Address and write data come straight from capture registers so they hold for the whole transaction.
  assign M_LB_RADDR = addr_q;
  assign M_LB_WADDR = addr_q;
  assign M_LB_WDATA = wdata_q;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_WRITE;
      addr_q      <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      rd_q        <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      M_LB_RREQ   <= 1'b0;
      M_LB_WREQ   <= 1'b0;
      RSP_VALID_O <= 1'b0;
      RSP_DATA_O  <= '0;
      RSP_ERR_O   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      M_LB_RREQ   <= rreq_d;
      M_LB_WREQ   <= wreq_d;
      RSP_VALID_O <= rsp_valid_d;
      RSP_DATA_O  <= rsp_data_d;
      RSP_ERR_O   <= rsp_err_d;
    end
  end

  // Requests are registered: a request is scheduled only after BUSY has been seen low,
  // because the bridge raises BUSY combinationally from the request itself.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mask_d      = mask_q;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    rreq_d      = 1'b0;
    wreq_d      = 1'b0;
    rsp_valid_d = RSP_VALID_O;
    rsp_data_d  = RSP_DATA_O;
    rsp_err_d   = RSP_ERR_O;

    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          op_d   = op_e'(CMD_OP_I);
          addr_d = CMD_ADDR_I;
          data_d = CMD_DATA_I;
          mask_d = CMD_MASK_I;
          case (op_e'(CMD_OP_I))
            OP_READ, OP_RMW: begin
              state_d = ST_RD_REQ;
              rreq_d  = 1'b1;
            end
            OP_WRITE: begin
              state_d = ST_WR_REQ;
              wreq_d  = 1'b1;
              wdata_d = CMD_DATA_I;
            end
            OP_RSVD: begin
              state_d     = ST_RSP;
              rsp_valid_d = 1'b1;
              rsp_data_d  = '0;
              rsp_err_d   = 1'b1;
            end
          endcase
        end
      end

      ST_RD_REQ: begin
        if (M_LB_RREQ) begin
          state_d = ST_RD_WAIT;
        end else if (timed_out) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end else if (!M_LB_BUSY) begin
          rreq_d = 1'b1;
        end
      end

      ST_RD_WAIT: begin
        if (M_LB_RFINISH) begin
          rd_d = M_LB_RDATA;
          if (op_q == OP_RMW) begin
            state_d = ST_WR_REQ;
            wdata_d = C_DATA_WIDTH'(merge_field(MERGE_W'(M_LB_RDATA), MERGE_W'(mask_q),
                                                MERGE_W'(data_q)));
          end else begin
            state_d     = ST_RSP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = M_LB_RDATA;
            rsp_err_d   = 1'b0;
          end
        end else if (timed_out) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end
      end

      ST_WR_REQ: begin
        if (M_LB_WREQ) begin
          state_d = ST_WR_WAIT;
        end else if (timed_out) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end else if (!M_LB_BUSY) begin
          wreq_d = 1'b1;
        end
      end

      ST_WR_WAIT: begin
        if (!M_LB_BUSY) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = (op_q == OP_RMW) ? rd_q : '0;
          rsp_err_d   = 1'b0;
        end else if (timed_out) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end
      end

      ST_RSP: begin
        if (RSP_READY_I) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {ST_RD_REQ, ST_RD_WAIT, ST_WR_REQ, ST_WR_WAIT}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

endmodule

// File: tb/tb_drp_rmw_sequencer.sv
// Directed bench for drp_rmw_sequencer against a small behavioural model of the bridge LB port.
module tb_drp_rmw_sequencer;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [DW-1:0] cmd_mask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata;
  logic          wreq, rreq;
  logic [DW-1:0] m_rdata;
  logic          m_rfinish;
  logic          m_busy;

  // Bridge model knobs and state
  int            wr_lat = 4;
  int            rd_lat = 6;
  logic [DW-1:0] rd_value = '0;
  bit            no_finish = 1'b0;
  bit            stuck = 1'b0;
  int            wr_cnt = 0;
  int            rd_cnt = 0;
  logic          rfinish_q = 1'b0;
  logic          tail_q = 1'b0;

  // Monitor records
  int            cyc = 0;
  int            n_rreq = 0, n_wreq = 0, n_both = 0;
  int            rreq_cyc = 0, wreq_cyc = 0;
  logic [AW-1:0] rreq_addr = '0, waddr_s = '0;
  logic [DW-1:0] wdata_s = '0;
  logic          last_busy = 1'b0, wreq_prev_busy = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  assign m_busy    = rreq | wreq | (wr_cnt != 0) | (rd_cnt != 0) | rfinish_q | tail_q | stuck;
  assign m_rfinish = rfinish_q;
  assign m_rdata   = rfinish_q ? rd_value : 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  drp_rmw_sequencer #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_TIMEOUT(TO)) dut (
    .CLK_I(clk), .RST_I(rst),
    .CMD_VALID_I(cmd_valid), .CMD_READY_O(cmd_ready), .CMD_OP_I(cmd_op),
    .CMD_ADDR_I(cmd_addr), .CMD_DATA_I(cmd_data), .CMD_MASK_I(cmd_mask),
    .RSP_VALID_O(rsp_valid), .RSP_READY_I(rsp_ready), .RSP_DATA_O(rsp_data), .RSP_ERR_O(rsp_err),
    .M_LB_WADDR(waddr), .M_LB_WDATA(wdata), .M_LB_WREQ(wreq),
    .M_LB_RADDR(raddr), .M_LB_RREQ(rreq),
    .M_LB_RDATA(m_rdata), .M_LB_RFINISH(m_rfinish), .M_LB_BUSY(m_busy)
  );

  // Cycle monitor plus bridge model; BUSY has a one-cycle tail after RFINISH.
  always @(posedge clk) begin
    if (rreq) begin n_rreq++; rreq_cyc = cyc; rreq_addr = raddr; end
    if (wreq) begin
      n_wreq++; wreq_cyc = cyc; waddr_s = waddr; wdata_s = wdata; wreq_prev_busy = last_busy;
    end
    if (rreq && wreq) n_both++;
    last_busy = m_busy;
    cyc++;
    rfinish_q <= 1'b0;
    tail_q    <= rfinish_q;
    if (wreq) wr_cnt <= wr_lat;
    else if (wr_cnt != 0) wr_cnt <= wr_cnt - 1;
    if (rreq) rd_cnt <= rd_lat;
    else if (rd_cnt != 0) begin
      rd_cnt <= rd_cnt - 1;
      if (rd_cnt == 1 && !no_finish) rfinish_q <= 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [DW-1:0] mask,
                          output bit ok, output int acc);
    ok = 1'b0; acc = -1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
    for (int i = 0; i < 64; i++) begin
      if (cmd_ready) begin ok = 1'b1; acc = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output bit got, output int rcyc);
    got = 1'b0; rcyc = -1;
    for (int i = 0; i < max; i++) begin
      if (rsp_valid) begin got = 1'b1; rcyc = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic ack_rsp;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({rsp_valid, rreq, wreq, rsp_err, cmd_ready} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {rsp_valid, rreq, wreq, rsp_err, cmd_ready});
    end
    n_tests++;
    if ({raddr, waddr, wdata, rsp_data} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {raddr, waddr, wdata, rsp_data});
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    @(negedge clk);
  endtask

  task automatic test_write;
    bit ok, got; int acc, rc, r0, w0;
    r0 = n_rreq; w0 = n_wreq; wr_lat = 4;
    send_cmd(2'd0, 16'h0042, 32'h0000_1234, 32'h0, ok, acc);
    wait_rsp(40, got, rc);
    n_tests++;
    if (!ok || !got) begin n_fail++; $display("FAIL wr_handshake: accepted %b responded %b expected 1 1", ok, got); end
    n_tests++;
    if (n_wreq - w0 != 1 || n_rreq != r0) begin
      n_fail++; $display("FAIL wr_pulses: wreq %0d rreq %0d expected 1 0", n_wreq - w0, n_rreq - r0);
    end
    n_tests++;
    if (waddr_s !== 16'h0042 || wdata_s !== 32'h0000_1234) begin
      n_fail++; $display("FAIL wr_addr_data: got %h/%h expected 0042/00001234", waddr_s, wdata_s);
    end
    n_tests++;
    if (wreq_cyc != acc + 1 || rc != wreq_cyc + 6) begin
      n_fail++; $display("FAIL wr_latency: wreq %0d rsp %0d expected %0d %0d", wreq_cyc, rc, acc + 1, acc + 7);
    end
    n_tests++;
    if (rsp_err !== 1'b0 || rsp_data !== 32'h0) begin
      n_fail++; $display("FAIL wr_rsp: got err %b data %h expected 0 0", rsp_err, rsp_data);
    end
    ack_rsp();
    n_tests++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_drop: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_read;
    bit ok, got; int acc, rc, r0, w0;
    r0 = n_rreq; w0 = n_wreq; rd_lat = 6; rd_value = 32'h0000_ABCD;
    send_cmd(2'd1, 16'h0010, 32'h0, 32'h0, ok, acc);
    wait_rsp(40, got, rc);
    n_tests++;
    if (!ok || !got || n_rreq - r0 != 1 || n_wreq != w0) begin
      n_fail++; $display("FAIL rd_pulses: ok %b got %b rreq %0d wreq %0d expected 1 1 1 0", ok, got, n_rreq - r0, n_wreq - w0);
    end
    n_tests++;
    if (rreq_addr !== 16'h0010) begin n_fail++; $display("FAIL rd_addr: got %h expected 0010", rreq_addr); end
    n_tests++;
    if (rreq_cyc != acc + 1 || rc != rreq_cyc + 8) begin
      n_fail++; $display("FAIL rd_latency: rreq %0d rsp %0d expected %0d %0d", rreq_cyc, rc, acc + 1, acc + 9);
    end
    n_tests++;
    if (rsp_data !== 32'h0000_ABCD || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL rd_rsp: got %h err %b expected 0000abcd 0", rsp_data, rsp_err);
    end
    ack_rsp();
  endtask

  task automatic test_rmw;
    bit ok, got; int acc, rc, r0, w0;
    r0 = n_rreq; w0 = n_wreq; rd_lat = 6; wr_lat = 4; rd_value = 32'h0000_1234;
    send_cmd(2'd2, 16'h0020, 32'h0000_0050, 32'h0000_00F0, ok, acc);
    wait_rsp(60, got, rc);
    n_tests++;
    if (!ok || !got || n_rreq - r0 != 1 || n_wreq - w0 != 1) begin
      n_fail++; $display("FAIL rmw_pulses: ok %b got %b rreq %0d wreq %0d expected 1 1 1 1", ok, got, n_rreq - r0, n_wreq - w0);
    end
    n_tests++;
    if (waddr_s !== 16'h0020 || wdata_s !== 32'h0000_1254) begin
      n_fail++; $display("FAIL rmw_wdata: got %h/%h expected 0020/00001254", waddr_s, wdata_s);
    end
    // RFINISH at +7 and the BUSY tail at +8 push the write to +10
    n_tests++;
    if (wreq_prev_busy !== 1'b0 || wreq_cyc != rreq_cyc + 10 || rc != rreq_cyc + 16) begin
      n_fail++; $display("FAIL rmw_timing: prev_busy %b wreq +%0d rsp +%0d expected 0 +10 +16", wreq_prev_busy, wreq_cyc - rreq_cyc, rc - rreq_cyc);
    end
    n_tests++;
    if (rsp_data !== 32'h0000_1234 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL rmw_rsp: got %h err %b expected 00001234 0", rsp_data, rsp_err);
    end
    ack_rsp();
  endtask

  task automatic test_reserved;
    bit ok, got; int acc, rc, r0, w0;
    r0 = n_rreq; w0 = n_wreq;
    send_cmd(2'd3, 16'h0099, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ok, acc);
    wait_rsp(10, got, rc);
    n_tests++;
    if (!ok || !got || rc != acc + 1) begin
      n_fail++; $display("FAIL rsvd_latency: ok %b got %b rsp %0d expected 1 1 %0d", ok, got, rc, acc + 1);
    end
    n_tests++;
    if (rsp_err !== 1'b1 || rsp_data !== 32'h0 || n_rreq != r0 || n_wreq != w0) begin
      n_fail++; $display("FAIL rsvd_rsp: err %b data %h pulses %0d expected 1 0 0", rsp_err, rsp_data, (n_rreq - r0) + (n_wreq - w0));
    end
    ack_rsp();
  endtask

  task automatic test_back_to_back;
    bit got; int acc, rc, r0, bad;
    logic [DW-1:0] held;
    r0 = n_rreq; rd_lat = 6; rd_value = 32'h5A5A_0001; bad = 0;
    stuck = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 16'h0030;
    repeat (4) begin @(negedge clk); if (cmd_ready !== 1'b0) bad++; end
    n_tests++;
    if (bad != 0 || n_rreq != r0) begin
      n_fail++; $display("FAIL b2b_hold_off: ready-high cycles %0d rreq %0d expected 0 0", bad, n_rreq - r0);
    end
    stuck = 1'b0;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b expected 1", cmd_ready); end
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(40, got, rc);
    n_tests++;
    if (!got || rreq_cyc != acc + 1 || rsp_data !== 32'h5A5A_0001) begin
      n_fail++; $display("FAIL b2b_read: got %b rreq %0d data %h expected 1 %0d 5a5a0001", got, rreq_cyc, rsp_data, acc + 1);
    end
    held = rsp_data; bad = 0;
    repeat (3) begin @(negedge clk); if (rsp_valid !== 1'b1 || rsp_data !== held || rsp_err !== 1'b0) bad++; end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL b2b_stall_stable: unstable cycles %0d expected 0", bad); end
    ack_rsp();
    n_tests++;
    if (rsp_valid !== 1'b0 || n_rreq - r0 != 1) begin
      n_fail++; $display("FAIL b2b_release: valid %b rreq %0d expected 0 1", rsp_valid, n_rreq - r0);
    end
  endtask

  task automatic test_timeout;
    bit ok, got; int acc, rc, r0, w0, bad;
    r0 = n_rreq; w0 = n_wreq; rd_lat = 3; no_finish = 1'b1;
    send_cmd(2'd2, 16'h0055, 32'h1, 32'h1, ok, acc);
    stuck = 1'b1;
    wait_rsp(40, got, rc);
    // Give-up decision lands 16 cycles after the request; the response registers one cycle later
    n_tests++;
    if (!ok || !got || rc != rreq_cyc + 17) begin
      n_fail++; $display("FAIL to_latency: ok %b got %b rsp +%0d expected 1 1 +17", ok, got, rc - rreq_cyc);
    end
    n_tests++;
    if (rsp_err !== 1'b1 || rsp_data !== 32'h0 || n_wreq != w0 || n_rreq - r0 != 1) begin
      n_fail++; $display("FAIL to_rsp: err %b data %h wreq %0d rreq %0d expected 1 0 0 1", rsp_err, rsp_data, n_wreq - w0, n_rreq - r0);
    end
    ack_rsp();
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 16'h0001; bad = 0;
    repeat (5) begin @(negedge clk); if (cmd_ready !== 1'b0) bad++; end
    cmd_valid = 1'b0;
    n_tests++;
    if (bad != 0 || n_rreq - r0 != 1) begin
      n_fail++; $display("FAIL to_stuck_ready: ready-high cycles %0d rreq %0d expected 0 1", bad, n_rreq - r0);
    end
    stuck = 1'b0; no_finish = 1'b0;
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL to_recover: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_reset_mid;
    bit ok, got; int acc, rc, r0;
    rd_lat = 10; rd_value = 32'h0000_0BAD;
    send_cmd(2'd1, 16'h0077, 32'h0, 32'h0, ok, acc);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({rsp_valid, rreq, wreq, rsp_err, cmd_ready} !== 5'b0 || {raddr, waddr, wdata, rsp_data} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: ctrl %b data %h expected 0 0", {rsp_valid, rreq, wreq, rsp_err, cmd_ready}, {raddr, waddr, wdata, rsp_data});
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy_ready: got %b expected 0", cmd_ready); end
    @(negedge clk);
    r0 = n_rreq; rd_lat = 3; rd_value = 32'h0000_C0DE;
    send_cmd(2'd1, 16'h0011, 32'h0, 32'h0, ok, acc);
    wait_rsp(60, got, rc);
    n_tests++;
    if (!ok || !got || n_rreq - r0 != 1 || rreq_addr !== 16'h0011) begin
      n_fail++; $display("FAIL mid_reset_next_cmd: ok %b got %b rreq %0d addr %h expected 1 1 1 0011", ok, got, n_rreq - r0, rreq_addr);
    end
    n_tests++;
    if (rsp_data !== 32'h0000_C0DE || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_rsp: got %h err %b expected 0000c0de 0", rsp_data, rsp_err);
    end
    ack_rsp();
  endtask

  task automatic test_exclusive;
    n_tests++;
    if (n_both != 0) begin n_fail++; $display("FAIL req_exclusive: overlap cycles %0d expected 0", n_both); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_rmw();
    test_reserved();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/drp_rmw_sequencer.md
Name: drp_rmw_sequencer

Overview:
- Command-level master for the LB port of the AXI-to-DRP bridge (LB mode enabled). Runs in that bridge's S_AXI_ACLK domain.
- Accepts single WRITE, READ and READ-MODIFY-WRITE commands over a valid/ready channel. Drives the LB request/busy protocol one transaction at a time and returns read data or an error.
- Lets firmware or an init engine change individual DRP bit fields without a CPU round trip.

Parameters:
- C_ADDR_WIDTH, 16: LB address width.
- C_DATA_WIDTH, 32: LB data width. Mask and command data use the same width.
- C_TIMEOUT, 4096: maximum cycles spent waiting for completion of one LB transaction. Must be at least 2.

Ports:
- CLK_I  in  1  clock; same clock as the bridge's AXI side.
- RST_I  in  1  synchronous, active-high reset.
- CMD_VALID_I  in  1  command valid.
- CMD_READY_O  out  1  command accepted when both VALID and READY are high.
- CMD_OP_I  in  2  operation: 0=WRITE, 1=READ, 2=RMW, 3=reserved.
- CMD_ADDR_I  in  C_ADDR_WIDTH  target address.
- CMD_DATA_I  in  C_DATA_WIDTH  write data (WRITE) or field value (RMW).
- CMD_MASK_I  in  C_DATA_WIDTH  RMW bit mask; 1 = replace the bit.
- RSP_VALID_O  out  1  response valid; held until accepted.
- RSP_READY_I  in  1  response accept.
- RSP_DATA_O  out  C_DATA_WIDTH  read data (READ), pre-modify data (RMW), 0 (WRITE/error).
- RSP_ERR_O  out  1  1 = timeout or reserved op.
- M_LB_WADDR  out  C_ADDR_WIDTH  LB write address.
- M_LB_WDATA  out  C_DATA_WIDTH  LB write data.
- M_LB_WREQ  out  1  one-cycle write request pulse.
- M_LB_RADDR  out  C_ADDR_WIDTH  LB read address.
- M_LB_RREQ  out  1  one-cycle read request pulse.
- M_LB_RDATA  in  C_DATA_WIDTH  read data; valid only while RFINISH is high.
- M_LB_RFINISH  in  1  one-cycle read completion.
- M_LB_BUSY  in  1  bridge busy. High combinationally in the request cycle; stays high until the DRP completes.

Behaviour:
- Reset: all outputs 0. State IDLE. Timeout counter 0. Captured registers 0.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RSP.
- IDLE:
  - CMD_READY_O = (state==IDLE) & ~M_LB_BUSY & ~RST_I.
  - On accept, capture op, addr, data and mask.
  - op READ or RMW -> RD_REQ. op WRITE -> WR_REQ. op 3 -> RSP with ERR=1 and no LB activity.
- RD_REQ:
  - If BUSY=0: RREQ=1 for exactly this cycle, RADDR = captured addr, then -> RD_WAIT.
  - Otherwise wait here; the timeout applies.
- RD_WAIT:
  - On RFINISH: capture RDATA into rd_q.
  - READ -> RSP. RMW -> WR_REQ with wdata = (rd_q & ~mask) | (data & mask).
  - RFINISH arriving in the same cycle as the request is impossible; ignore it.
- WR_REQ:
  - Wait for BUSY=0; this covers the bridge's one-cycle BUSY tail after RFINISH.
  - Then WREQ=1 for exactly one cycle with WADDR/WDATA, then -> WR_WAIT.
- WR_WAIT: first cycle with BUSY=0 -> RSP. BUSY is guaranteed high in the first cycle after the request.
- Addresses and data are registered and stay stable from the request cycle until the transaction completes.
- Timeout:
  - Counter clears on every state change and increments in RD_REQ, RD_WAIT, WR_REQ and WR_WAIT.
  - At C_TIMEOUT-1: -> RSP with ERR=1, RSP_DATA_O=0. No write is issued for an RMW whose read timed out.
- RSP:
  - RSP_VALID_O=1 with stable data/err until RSP_READY_I, then -> IDLE.
  - Latency when BUSY is idle: READ accept T, RREQ T+1, RSP_VALID the cycle after RFINISH.
- Any request cycle never has RREQ and WREQ both high.
- RST_I mid-operation: immediate return to IDLE with outputs 0. An in-flight bridge transaction is not tracked; the next command waits in IDLE for BUSY=0 via CMD_READY_O.
- After a timeout with BUSY stuck high, CMD_READY_O stays low. No new requests are issued.

Decomposition:
- Shared package drp_seq_pkg holds:
  - op encodings OP_WRITE/OP_READ/OP_RMW;
  - state encodings;
  - the merge function (old & ~mask) | (new & mask).
- A single module is sufficient; no sub-module is warranted.

Test Plan:
- WRITE addr 0x0042 data 0x0000_1234, BFM holds BUSY 5 cycles -> one WREQ pulse with WADDR=0x0042, WDATA=0x1234; RSP_VALID one cycle after BUSY falls, ERR=0, DATA=0.
- READ addr 0x0010, BFM returns RFINISH with RDATA=0x0000_ABCD after 7 cycles -> one RREQ pulse; RSP_DATA_O=0xABCD, ERR=0.
- RMW addr 0x0020, mask 0x0000_00F0, data 0x0000_0050, old value 0x0000_1234 -> RREQ, then WREQ only after BUSY low with WDATA=0x0000_1254; RSP_DATA_O=0x1234.
- BFM never asserts RFINISH, C_TIMEOUT=16 -> RSP ERR=1 within 16 cycles of RREQ; no WREQ; CMD_READY_O low while BUSY stuck.
- CMD_VALID held while BUSY=1 from a prior transaction, plus RSP_READY_I low for 3 cycles -> no accept until BUSY=0; RSP_VALID/DATA stable for the 3 stall cycles.
- RST_I asserted in RD_WAIT -> next cycle all outputs 0, state IDLE; subsequent READ completes normally; op=3 -> immediate ERR=1 response, no LB pulses.
